// File: rtl/flit_rank_if.sv
// Flit ranking bus: four input flit channels and four ranked output slots.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

interface flit_rank_if #(
  parameter int AGE_WIDTH = 8,
  parameter int ID_WIDTH  = 4
);
  logic                       vld_in_0, vld_in_1, vld_in_2, vld_in_3;
  logic [AGE_WIDTH-1:0]       age_in_0, age_in_1, age_in_2, age_in_3;
  logic [ID_WIDTH-1:0]        src_in_0, src_in_1, src_in_2, src_in_3;
  logic                       mc_in_0, mc_in_1, mc_in_2, mc_in_3;
  logic [`NUM_PORT-2:0]       ppv_in_0, ppv_in_1, ppv_in_2, ppv_in_3;
  logic                       mc_0, mc_1, mc_2, mc_3;
  logic [`NUM_PORT-2:0]       ppv_0, ppv_1, ppv_2, ppv_3;
  logic [1:0]                 perm_0, perm_1, perm_2, perm_3;
  logic                       vld_0, vld_1, vld_2, vld_3;
  logic [`PC_INDEX_WIDTH-1:0] numFlit_out;
  logic [ID_WIDTH-1:0]        golden_id;

  modport master (
    output vld_in_0, vld_in_1, vld_in_2, vld_in_3,
           age_in_0, age_in_1, age_in_2, age_in_3,
           src_in_0, src_in_1, src_in_2, src_in_3,
           mc_in_0, mc_in_1, mc_in_2, mc_in_3,
           ppv_in_0, ppv_in_1, ppv_in_2, ppv_in_3,
    input  mc_0, mc_1, mc_2, mc_3, ppv_0, ppv_1, ppv_2, ppv_3,
           perm_0, perm_1, perm_2, perm_3, vld_0, vld_1, vld_2, vld_3,
           numFlit_out, golden_id
  );

  modport slave (
    input  vld_in_0, vld_in_1, vld_in_2, vld_in_3,
           age_in_0, age_in_1, age_in_2, age_in_3,
           src_in_0, src_in_1, src_in_2, src_in_3,
           mc_in_0, mc_in_1, mc_in_2, mc_in_3,
           ppv_in_0, ppv_in_1, ppv_in_2, ppv_in_3,
    output mc_0, mc_1, mc_2, mc_3, ppv_0, ppv_1, ppv_2, ppv_3,
           perm_0, perm_1, perm_2, perm_3, vld_0, vld_1, vld_2, vld_3,
           numFlit_out, golden_id
  );
endinterface

// File: rtl/flit_rank.sv
// Ranks four flits by {valid, golden, age} with lower index breaking ties; outputs registered.
// Optional macro GOLDEN_EN builds the epoch counter and the golden-source priority term.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module flit_rank #(
  parameter int AGE_WIDTH = 8,
  parameter int ID_WIDTH  = 4,
  parameter int EPOCH_LEN = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  flit_rank_if.slave bus
);
  localparam int PPV_W = `NUM_PORT - 1;
  localparam int PCW   = `PC_INDEX_WIDTH;
  localparam int KEY_W = AGE_WIDTH + 2;

  logic [3:0]           vld_in, mc_in, golden_hit;
  logic [AGE_WIDTH-1:0] age_in [4];
  logic [ID_WIDTH-1:0]  src_in [4];
  logic [PPV_W-1:0]     ppv_in [4];
  logic [KEY_W-1:0]     key [4];
  logic [1:0]           rank [4];
  logic [ID_WIDTH-1:0]  golden_cur;

  logic [3:0]       vld_d, vld_q, mc_d, mc_q;
  logic [1:0]       perm_d [4];
  logic [1:0]       perm_q [4];
  logic [PPV_W-1:0] ppv_d [4];
  logic [PPV_W-1:0] ppv_q [4];
  logic [PCW-1:0]   num_d, num_q;

  assign vld_in = {bus.vld_in_3, bus.vld_in_2, bus.vld_in_1, bus.vld_in_0};
  assign mc_in  = {bus.mc_in_3, bus.mc_in_2, bus.mc_in_1, bus.mc_in_0};
  assign age_in[0] = bus.age_in_0;
  assign age_in[1] = bus.age_in_1;
  assign age_in[2] = bus.age_in_2;
  assign age_in[3] = bus.age_in_3;
  assign src_in[0] = bus.src_in_0;
  assign src_in[1] = bus.src_in_1;
  assign src_in[2] = bus.src_in_2;
  assign src_in[3] = bus.src_in_3;
  assign ppv_in[0] = bus.ppv_in_0;
  assign ppv_in[1] = bus.ppv_in_1;
  assign ppv_in[2] = bus.ppv_in_2;
  assign ppv_in[3] = bus.ppv_in_3;

`ifdef GOLDEN_EN
  localparam int EPOCH_W = $clog2(EPOCH_LEN);
  logic [EPOCH_W-1:0]  epoch_d, epoch_q;
  logic [ID_WIDTH-1:0] golden_d, golden_q;

  // golden_id advances on the cycle the epoch counter wraps back to 0
  always_comb begin
    epoch_d  = epoch_q + 1'b1;
    golden_d = golden_q;
    if (epoch_q == EPOCH_W'(EPOCH_LEN - 1)) begin
      epoch_d  = '0;
      golden_d = golden_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      epoch_q  <= '0;
      golden_q <= '0;
    end else begin
      epoch_q  <= epoch_d;
      golden_q <= golden_d;
    end
  end

  assign golden_cur = golden_q;

  always_comb begin
    golden_hit = '0;
    for (int k = 0; k < 4; k++) golden_hit[k] = (src_in[k] == golden_q);
  end
`else
  logic [4*ID_WIDTH-1:0] unused_src;
  assign unused_src = {src_in[3], src_in[2], src_in[1], src_in[0]};
  assign golden_cur = '0;
  assign golden_hit = '0;
`endif

  // Invalid channels collapse to key 0 so their payload cannot influence ordering
  always_comb begin
    for (int k = 0; k < 4; k++)
      key[k] = vld_in[k] ? {1'b1, golden_hit[k], age_in[k]} : '0;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rank[k] = '0;
      for (int j = 0; j < 4; j++) begin
        if (j != k && (key[j] > key[k] || (key[j] == key[k] && j < k)))
          rank[k] = rank[k] + 2'd1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      perm_d[r] = 2'(r);
      for (int k = 0; k < 4; k++)
        if (rank[k] == 2'(r)) perm_d[r] = 2'(k);
    end
    for (int r = 0; r < 4; r++) begin
      vld_d[r] = vld_in[perm_d[r]];
      mc_d[r]  = vld_in[perm_d[r]] & mc_in[perm_d[r]];
      ppv_d[r] = vld_in[perm_d[r]] ? ppv_in[perm_d[r]] : '0;
    end
    num_d = PCW'({2'b00, vld_in[0]} + {2'b00, vld_in[1]} +
                 {2'b00, vld_in[2]} + {2'b00, vld_in[3]});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      mc_q  <= '0;
      num_q <= '0;
      for (int r = 0; r < 4; r++) begin
        perm_q[r] <= 2'(r);
        ppv_q[r]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      mc_q  <= mc_d;
      num_q <= num_d;
      for (int r = 0; r < 4; r++) begin
        perm_q[r] <= perm_d[r];
        ppv_q[r]  <= ppv_d[r];
      end
    end
  end

  assign bus.vld_0 = vld_q[0];
  assign bus.vld_1 = vld_q[1];
  assign bus.vld_2 = vld_q[2];
  assign bus.vld_3 = vld_q[3];
  assign bus.mc_0  = mc_q[0];
  assign bus.mc_1  = mc_q[1];
  assign bus.mc_2  = mc_q[2];
  assign bus.mc_3  = mc_q[3];
  assign bus.ppv_0 = ppv_q[0];
  assign bus.ppv_1 = ppv_q[1];
  assign bus.ppv_2 = ppv_q[2];
  assign bus.ppv_3 = ppv_q[3];
  assign bus.perm_0 = perm_q[0];
  assign bus.perm_1 = perm_q[1];
  assign bus.perm_2 = perm_q[2];
  assign bus.perm_3 = perm_q[3];
  assign bus.numFlit_out = num_q;
  assign bus.golden_id   = golden_cur;
endmodule

// File: tb/tb_flit_rank.sv
// Randomised scoreboard bench for flit_rank: a sort-based reference model predicts each registered
// ranking; a separate monitor pops predictions one cycle later and compares them with the DUT.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module tb_flit_rank;
  localparam int AGE_W = 8;
  localparam int ID_W  = 2;
  localparam int EPOCH = 4;
  localparam int PPV_W = `NUM_PORT - 1;
`ifdef GOLDEN_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]            vld;
    logic [3:0][1:0]       perm;
    logic [3:0]            mc;
    logic [3:0][PPV_W-1:0] ppv;
    logic [2:0]            num;
    logic [ID_W-1:0]       golden;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic                  s_rst_n = 1'b0;
  logic [3:0]            s_vld = '0;
  logic [3:0][AGE_W-1:0] s_age = '0;
  logic [3:0][ID_W-1:0]  s_src = '0;
  logic [3:0]            s_mc = '0;
  logic [3:0][PPV_W-1:0] s_ppv = '0;

  exp_t            exp_q[$];
  int              n_vec = 0;
  int              n_miss = 0;
  int              m_epoch = 0;
  logic [ID_W-1:0] m_golden = '0;

  flit_rank_if #(.AGE_WIDTH(AGE_W), .ID_WIDTH(ID_W)) bus();

  flit_rank #(.AGE_WIDTH(AGE_W), .ID_WIDTH(ID_W), .EPOCH_LEN(EPOCH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  assign reset_n = s_rst_n;
  assign bus.vld_in_0 = s_vld[0];
  assign bus.vld_in_1 = s_vld[1];
  assign bus.vld_in_2 = s_vld[2];
  assign bus.vld_in_3 = s_vld[3];
  assign bus.age_in_0 = s_age[0];
  assign bus.age_in_1 = s_age[1];
  assign bus.age_in_2 = s_age[2];
  assign bus.age_in_3 = s_age[3];
  assign bus.src_in_0 = s_src[0];
  assign bus.src_in_1 = s_src[1];
  assign bus.src_in_2 = s_src[2];
  assign bus.src_in_3 = s_src[3];
  assign bus.mc_in_0 = s_mc[0];
  assign bus.mc_in_1 = s_mc[1];
  assign bus.mc_in_2 = s_mc[2];
  assign bus.mc_in_3 = s_mc[3];
  assign bus.ppv_in_0 = s_ppv[0];
  assign bus.ppv_in_1 = s_ppv[1];
  assign bus.ppv_in_2 = s_ppv[2];
  assign bus.ppv_in_3 = s_ppv[3];

  // Reference: selection-sort the valid channels by (golden, age) descending, then append the rest
  function automatic exp_t predict();
    exp_t e;
    int   order[$];
    bit   taken[4];
    logic [3:0] gflag;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      gflag[k] = GEN && (s_src[k] == m_golden);
      taken[k] = 1'b0;
    end
    for (int n = 0; n < 4; n++) begin
      int best;
      best = -1;
      for (int k = 0; k < 4; k++) begin
        if (s_vld[k] && !taken[k]) begin
          if (best < 0 || {gflag[k], s_age[k]} > {gflag[best], s_age[best]}) best = k;
        end
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        order.push_back(best);
      end
    end
    for (int k = 0; k < 4; k++) if (!s_vld[k]) order.push_back(k);
    for (int r = 0; r < 4; r++) begin
      e.perm[r] = 2'(order[r]);
      e.vld[r]  = s_vld[order[r]];
      e.mc[r]   = s_vld[order[r]] & s_mc[order[r]];
      e.ppv[r]  = s_vld[order[r]] ? s_ppv[order[r]] : '0;
    end
    e.num = 3'($countones(s_vld));
    return e;
  endfunction

  task automatic applyStimulus(input logic rst_n_i, input logic [3:0] v,
                               input logic [3:0][AGE_W-1:0] a, input logic [3:0][ID_W-1:0] s,
                               input logic [3:0] m, input logic [3:0][PPV_W-1:0] p);
    exp_t e;
    @(posedge clk);
    #2;
    s_rst_n = rst_n_i;
    s_vld = v;
    s_age = a;
    s_src = s;
    s_mc  = m;
    s_ppv = p;
    if (rst_n_i) begin
      e = predict();
    end else begin
      e = '0;
      for (int r = 0; r < 4; r++) e.perm[r] = 2'(r);
    end
    if (!rst_n_i) begin
      m_epoch  = 0;
      m_golden = '0;
    end else if (GEN) begin
      if (m_epoch == EPOCH - 1) begin
        m_epoch  = 0;
        m_golden = m_golden + 1'b1;
      end else begin
        m_epoch++;
      end
    end
    e.golden = m_golden;
    exp_q.push_back(e);
  endtask

  task automatic randomStim(input logic rst_n_i);
    logic [3:0]            v, m;
    logic [3:0][AGE_W-1:0] a;
    logic [3:0][ID_W-1:0]  s;
    logic [3:0][PPV_W-1:0] p;
    v = 4'($urandom);
    m = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      a[k] = ($urandom_range(0, 1) == 0) ? AGE_W'($urandom_range(0, 3)) : AGE_W'($urandom);
      s[k] = ID_W'($urandom);
      p[k] = PPV_W'($urandom);
    end
    applyStimulus(rst_n_i, v, a, s, m, p);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0]            vld;
    logic [3:0][1:0]       perm;
    logic [3:0][PPV_W-1:0] ppv;
    logic [3:0]            seen;
    vld  = {bus.vld_3, bus.vld_2, bus.vld_1, bus.vld_0};
    perm = {bus.perm_3, bus.perm_2, bus.perm_1, bus.perm_0};
    ppv  = {bus.ppv_3, bus.ppv_2, bus.ppv_1, bus.ppv_0};
    cmp("vld", 64'(vld), 64'(e.vld));
    cmp("perm", 64'(perm), 64'(e.perm));
    cmp("mc", 64'({bus.mc_3, bus.mc_2, bus.mc_1, bus.mc_0}), 64'(e.mc));
    cmp("ppv", 64'(ppv), 64'(e.ppv));
    cmp("numFlit_out", 64'(bus.numFlit_out), 64'(e.num));
    cmp("golden_id", 64'(bus.golden_id), 64'(e.golden));
    seen = '0;
    for (int r = 0; r < 4; r++) seen[perm[r]] = 1'b1;
    cmp("perm_is_permutation", 64'(seen), 64'hF);
    cmp("vld_prefix_ones", 64'(vld inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF}), 64'd1);
    cmp("num_vs_vld_popcount", 64'(bus.numFlit_out), 64'($countones(vld)));
  endtask

  // Monitor: each prediction queued before an edge is checked just after that edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0][PPV_W-1:0] pv;
    pv = {PPV_W'(4'h9), PPV_W'(4'h5), PPV_W'(4'hC), PPV_W'(4'h3)};
    randomStim(1'b0);
    randomStim(1'b0);
    // First sample after reset sees golden_id=0: source 0 on ch3 should win despite age 1
    applyStimulus(1'b1, 4'hF, {8'd1, 8'd200, 8'd200, 8'd200}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'hA, pv);
    applyStimulus(1'b1, 4'hF, {8'd5, 8'd40, 8'd40, 8'd10}, {2'd3, 2'd3, 2'd3, 2'd3}, 4'h6, pv);
    applyStimulus(1'b1, 4'b0101, {8'd99, 8'd7, 8'd99, 8'd3}, {2'd3, 2'd3, 2'd3, 2'd3}, 4'hF, pv);
    applyStimulus(1'b1, 4'b0000, {8'd9, 8'd8, 8'd7, 8'd6}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'hF, pv);
    applyStimulus(1'b0, 4'hF, {8'd1, 8'd2, 8'd3, 8'd4}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'hF, pv);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 4'h0, '0, '0, '0, '0);
    for (int i = 0; i < 10000; i++)
      randomStim(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/flit_rank.md
FLIT_RANK -- requirements
Module: flit_rank

Interface
REQ-001 Parameter AGE_WIDTH, default 8: width of each flit's age field; a larger value means an older flit.
REQ-002 Parameter ID_WIDTH, default 4: width of each flit's source-node ID.
REQ-003 Parameter EPOCH_LEN, default 256: golden-epoch length in cycles; legal range 2..65535.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Ports vld_in_0..3, input, 1 bit each: a flit is present on input channel k.
REQ-007 Ports age_in_0..3, input, AGE_WIDTH each: age of the flit on channel k.
REQ-008 Ports src_in_0..3, input, ID_WIDTH each: source-node ID of the flit on channel k.
REQ-009 Ports mc_in_0..3, input, 1 bit each: multicast flag of the flit on channel k.
REQ-010 Ports ppv_in_0..3, input, `NUM_PORT-1 bits each: productive-port vector of the flit on channel k.
REQ-011 Ports mc_0..3, output, 1 bit each: multicast flag of the rank-r flit (rank 0 is highest priority).
REQ-012 Ports ppv_0..3, output, `NUM_PORT-1 bits each: productive-port vector of the rank-r flit.
REQ-013 Ports perm_0..3, output, 2 bits each: index of the input channel that holds rank r.
REQ-014 Ports vld_0..3, output, 1 bit each: rank r holds a valid flit.
REQ-015 Port numFlit_out, output, `PC_INDEX_WIDTH bits: number of valid input flits, zero-extended.
REQ-016 Port golden_id, output, ID_WIDTH bits: the current golden source ID.

Function
REQ-017 The block shall register all outputs, so the ranking of the inputs sampled at edge N appears after edge N, with a latency of exactly 1 cycle and no stall.
REQ-018 The priority key shall be {valid, golden, age}, compared unsigned with valid as the most significant bit; golden = (src_in_k == golden_id) when GOLDEN_EN is defined, and 0 otherwise.
REQ-019 Equal keys shall be resolved in favour of the lower input index, so the ranking is a strict total order and perm_0..3 is always a permutation of 0..3.
REQ-020 The ranking shall place invalid channels after every valid channel, ordered by ascending index, with vld_r=0, mc_r=0 and ppv_r=0.
REQ-021 numFlit_out shall equal the popcount of vld_in_0..3, giving a range of 0..4.
REQ-022 An epoch counter shall count 0..EPOCH_LEN-1 and wrap to 0.
REQ-023 On the cycle the epoch counter wraps, golden_id shall increment modulo 2^ID_WIDTH, so all-ones wraps to 0.
REQ-024 The ranking sampled in a cycle shall use the golden_id value held before that edge; a golden_id change shall affect only the next sample.
REQ-025 With all four inputs invalid, the outputs shall be vld=0000, perm=0,1,2,3, mc=0, ppv=0 and numFlit_out=0.
REQ-026 Inputs on an invalid channel (age, src, mc, ppv) shall not affect any output.

Reset
REQ-027 While reset_n=0 at a rising edge, the block shall clear all outputs: vld, mc, ppv and numFlit_out to 0, perm_r to r, the epoch counter to 0 and golden_id to 0.
REQ-028 A reset asserted mid-operation shall discard the sample of that cycle.
REQ-029 The first sample shall be taken at the first edge with reset_n=1, and its ranking shall appear after that edge.

Configuration
REQ-030 Macro GOLDEN_EN: when defined, the epoch counter and golden term shall be built and golden_id shall track the epoch.
REQ-031 When GOLDEN_EN is undefined, the epoch counter shall not be built, golden_id shall be tied to 0, and ranking shall use age and index only.

Verification
REQ-032 Scenario: all valid, ages 10,40,40,5, no golden -> perm=1,2,0,3 and numFlit_out=4 one cycle later.
REQ-033 Scenario: vld=0101, ages 3,99,7,99 -> perm=2,0,1,3, vld_0..3=1,1,0,0, rank-2 and rank-3 ppv=0, numFlit_out=2.
REQ-034 Scenario: GOLDEN_EN, golden_id=0, src=0 on ch3 with age 1, others age 200 -> perm_0=3.
REQ-035 Scenario: GOLDEN_EN, EPOCH_LEN=4, 8 cycles from reset -> golden_id 0→1 after 4 edges, 1→2 after 8 edges; with ID_WIDTH=2 the 4th increment wraps golden_id to 0.
REQ-036 Scenario: reset_n pulled low for one cycle mid-stream with valid inputs -> next outputs vld=0000, perm=0,1,2,3, golden_id=0.
REQ-037 Scenario: random inputs for 10k cycles -> each cycle perm is a permutation, vld is prefix-ones, numFlit_out matches the popcount, and the ranking matches a reference sort.
